// File: rtl/if_id_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: owns the PC, latches the
// fetched word, decodes its fields and handles branch redirect, stall, bubble and HLT.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             br_taken_n,
  input  logic [31:0]      br_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      ir,
  output logic [31:0]      npc,
  output logic [5:0]       opcode,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [31:0]      imm_sext,
  output logic             ir_valid,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  localparam logic [5:0] OP_HLT = 6'b111111;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [31:0]      npc_q, npc_d;
  logic             ir_valid_q, ir_valid_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    npc_d       = npc_q;
    ir_valid_d  = ir_valid_q;
    fetch_cnt_d = fetch_cnt_q;
    case (state_q)
      RUN: begin
        if (!br_taken_n) begin
          // Redirect beats stall and HLT: the word fetched this cycle is on the wrong path.
          pc_d       = br_target;
          ir_d       = 32'h0;
          npc_d      = 32'h0;
          ir_valid_d = 1'b0;
        end else if (!stall) begin
          ir_d        = imem_rdata;
          npc_d       = pc_q + 32'd1;
          ir_valid_d  = 1'b1;
          fetch_cnt_d = sat_inc(fetch_cnt_q);
          if (imem_rdata[31:26] == OP_HLT) begin
            state_d = HALT;
          end else begin
            pc_d = pc_q + 32'd1;
          end
        end
      end
      HALT: ;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      ir_q        <= 32'h0;
      npc_q       <= 32'h0;
      ir_valid_q  <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      npc_q       <= npc_d;
      ir_valid_q  <= ir_valid_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign imem_addr = pc_q;
  assign ir        = ir_q;
  assign npc       = npc_q;
  assign opcode    = ir_q[31:26];
  assign rs        = ir_q[25:21];
  assign rt        = ir_q[20:16];
  assign rd        = ir_q[15:11];
  assign imm_sext  = {{16{ir_q[15]}}, ir_q[15:0]};
  assign ir_valid  = ir_valid_q;
  assign halted    = (state_q == HALT);
  assign fetch_cnt = fetch_cnt_q;

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Instruction-fetch stage and IF/ID pipeline register of the MIPS processor. It holds the PC and drives the instruction-memory address. Each cycle it latches the fetched word and presents the decoded fields, including the 6-bit opcode consumed by the control units. It also handles branch redirect, stall, bubble insertion and HLT.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word address).
- CNT_W, 16, width of the fetched-instruction counter.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  high: hold PC and IF/ID contents.
- br_taken_n  in  1  active-low branch-taken flag from the branch condition unit; low = redirect.
- br_target  in  32  branch target word address, valid when br_taken_n = 0.
- imem_addr  out  32  instruction-memory address, combinationally equal to pc.
- imem_rdata  in  32  instruction word at imem_addr, combinational read.
- ir  out  32  latched instruction.
- npc  out  32  pc+1 of the latched instruction.
- opcode  out  6  ir[31:26].
- rs  out  5  ir[25:21].
- rt  out  5  ir[20:16].
- rd  out  5  ir[15:11].
- imm_sext  out  32  sign-extended ir[15:0].
- ir_valid  out  1  IF/ID holds a real instruction, not a bubble.
- halted  out  1  high once HLT has been latched.
- fetch_cnt  out  CNT_W  count of instructions latched valid; saturates.

## Operation
- The PC is word-addressed and increments by 1.
- Opcodes: ADD–MUL are 0–5, LW is 8, SW is 9, ADDI/SUBI/SLTI are 10–12, BNEQZ is 13, BEQZ is 14, HLT is 6'b111111.
- Bubble: ir = 32'h0, which is ADD R0,R0,R0, with ir_valid = 0.
- Two states, RUN and HALT. Reset enters RUN.
- In RUN, each rising edge applies exactly one of the following, in priority order:
  1. br_taken_n = 0: pc <= br_target. IF/ID <= bubble. This holds regardless of stall or the fetched opcode.
  2. stall = 1: pc and IF/ID hold. fetch_cnt holds.
  3. imem_rdata[31:26] = 6'b111111: IF/ID <= the fetched word with ir_valid = 1, npc <= pc+1. pc holds. State goes to HALT and halted = 1. fetch_cnt increments.
  4. Otherwise: IF/ID <= the fetched word with ir_valid = 1, npc <= pc+1, pc <= pc+1. fetch_cnt increments.
- In HALT, pc and IF/ID are frozen with ir = HLT and ir_valid = 1. stall and br_taken_n are ignored. Only rst_n exits HALT.
- fetch_cnt saturates at all-ones and never wraps.
- pc wraps from 32'hFFFF_FFFF to 0 with no flag.
- The decoded fields are combinational slices of the ir register. There is no extra latency.
- br_taken_n = x/z is not a legal input. The bench must drive it to 0 or 1 at all times.

## Timing
- Reset values while rst_n = 0, applied immediately and asynchronously:
  - pc = RESET_PC, so imem_addr = RESET_PC.
  - ir = 0, npc = 0, ir_valid = 0.
  - halted = 0, fetch_cnt = 0, state = RUN.
- The first edge after rst_n rises latches imem[RESET_PC] into ir, and pc becomes RESET_PC+1.
- Fetch-to-decode latency: 1 cycle. The opcode is valid at the control units one clock after imem_addr presents the address.
- Branch penalty: the instruction latched on the redirect edge is a bubble. The next edge latches imem[br_target].
- If reset is asserted mid-operation, including in HALT or during a stall, all state clears within the same cycle without waiting for clk.
- stall and br_taken_n are sampled only at the rising edge of clk.

## Test plan
- Reset and sequential fetch: RESET_PC = 0, imem[0..2] = ADD, SUB, LW. Release rst_n, then 3 edges → opcode sequence 0, 1, 8; npc 1, 2, 3; ir_valid = 1; fetch_cnt = 3; imem_addr = 3.
- Stall: assert stall for 2 edges after the first fetch → ir, pc and fetch_cnt unchanged. Deassert → the next fetch resumes at the held pc.
- Branch with stall: pc = 5, br_taken_n = 0, br_target = 20, stall = 1 → after the edge, pc = 20, ir = 0, ir_valid = 0. The next edge gives ir = imem[20].
- HLT: imem[4] = 32'hFC00_0000 → after latching it, halted = 1 and opcode = 63. Then drive br_taken_n = 0 for 3 edges → pc stays at 4 and ir is unchanged.
- Asynchronous reset in HALT: pulse rst_n low between clock edges → pc = RESET_PC, halted = 0, ir_valid = 0, fetch_cnt = 0 immediately, without a clock edge.
- Counter saturation: CNT_W = 2, run 5 fetches → fetch_cnt = 3.
